// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int         OVERSAMPLE_c = 16;
    localparam logic [3:0] MID_TICK_c   = 4'd7;
    localparam logic [3:0] LAST_TICK_c  = 4'(OVERSAMPLE_c - 1);
    localparam int         DATA_BITS_c  = 8;

    function automatic logic even_parity(input logic [DATA_BITS_c-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO with occupancy count and overrun pulse.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic [DATA_BITS_c-1:0] wr_data_i,
    input  logic                   rd_en_i,
    output logic [DATA_BITS_c-1:0] dout_o,
    output logic [DEPTH_LOG2:0]    count_o,
    output logic                   empty_o,
    output logic                   overrun_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_BITS_c-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic                   overrun_q, overrun_d;
    logic                   full, empty, do_rd, do_wr;

    assign empty = (count_q == '0);
    assign full  = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));

    // A full FIFO still accepts a write when the head is popped on the same edge.
    always_comb begin
        do_rd     = rd_en_i && !empty;
        do_wr     = wr_en_i && (!full || do_rd);
        overrun_d = wr_en_i && full && !do_rd;
        count_d   = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (!do_wr && do_rd) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign dout_o    = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign empty_o   = empty;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled 8N1 UART receiver feeding a FWFT FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with parity checking.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   clk210_p,
    input  logic                   reset_p,
    input  logic                   baud_16_x_p,
    input  logic                   rx_p,
    output logic [DATA_BITS_c-1:0] fifo_rx_dout_p,
    input  logic                   fifo_rx_rd_en_p,
    output logic [DEPTH_LOG2:0]    fifo_rx_data_count_p,
    output logic                   fifo_rx_empty_p,
    output logic                   rx_busy_p,
    output logic                   framing_error_p,
    output logic                   overrun_p,
    output logic                   parity_error_p
);

    localparam logic [2:0] LAST_BIT_c = 3'(DATA_BITS_c - 1);

    logic                   rx_meta_q, rx_s_q;
    rx_state_e              state_q, state_d;
    logic [3:0]             tick_q, tick_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS_c-1:0] shift_q, shift_d;
    logic                   fe_q, fe_d;
    logic                   wr_en;
`ifdef UART_RX_PARITY_EN
    logic                   par_err_q, par_err_d;
    logic                   pe_q, pe_d;
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        fe_d    = 1'b0;
        wr_en   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
        pe_d      = 1'b0;
`endif
        if (baud_16_x_p) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == MID_TICK_c) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s_q ? IDLE : DATA;
                    end
                end
                DATA: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == LAST_TICK_c) begin
                        shift_d = {rx_s_q, shift_q[DATA_BITS_c-1:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == LAST_BIT_c) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == LAST_TICK_c) begin
                        par_err_d = (rx_s_q != even_parity(shift_q));
                        state_d   = STOP;
                    end
                end
`endif
                STOP: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == LAST_TICK_c) begin
                        state_d = IDLE;
                        if (!rx_s_q) begin
                            fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_err_q) begin
                            pe_d = 1'b1;
`endif
                        end else begin
                            wr_en = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk210_p) begin
        if (reset_p) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            fe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
            pe_q      <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx_p;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            fe_q      <= fe_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
            pe_q      <= pe_d;
`endif
        end
    end

    uart_rx_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i     (clk210_p),
        .rst_i     (reset_p),
        .wr_en_i   (wr_en),
        .wr_data_i (shift_q),
        .rd_en_i   (fifo_rx_rd_en_p),
        .dout_o    (fifo_rx_dout_p),
        .count_o   (fifo_rx_data_count_p),
        .empty_o   (fifo_rx_empty_p),
        .overrun_o (overrun_p)
    );

    assign rx_busy_p       = (state_q != IDLE);
    assign framing_error_p = fe_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error_p  = pe_q;
`else
    assign parity_error_p  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames, FIFO reads checked by a monitor.
module tb_uart_rx;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud = 1'b0;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] dout;
    logic [4:0] cnt;
    logic       empty, busy, fe, ov, pe;

    int vectors = 0;
    int miscompares = 0;
    int fe_n = 0;
    int ov_n = 0;
    int pe_n = 0;
    logic [7:0] exp_q[$];

    uart_rx #(.DEPTH_LOG2(4)) dut (
        .clk210_p             (clk),
        .reset_p              (reset),
        .baud_16_x_p          (baud),
        .rx_p                 (rx),
        .fifo_rx_dout_p       (dout),
        .fifo_rx_rd_en_p      (rd_en),
        .fifo_rx_data_count_p (cnt),
        .fifo_rx_empty_p      (empty),
        .rx_busy_p            (busy),
        .framing_error_p      (fe),
        .overrun_p            (ov),
        .parity_error_p       (pe)
    );

    initial forever #5 clk = ~clk;

    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            baud = (div == N - 1);
            div = (div + 1) % N;
        end
    end

    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (fe === 1'b1) fe_n++;
        if (ov === 1'b1) ov_n++;
        if (pe === 1'b1) pe_n++;
        if (rd_en && !empty) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_pop: got %02h, nothing expected", dout);
            end else begin
                e = exp_q.pop_front();
                if (dout !== e) begin
                    miscompares++;
                    $display("FAIL sb_pop: got %02h, expected %02h", dout, e);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (baud !== 1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic par, input bit rd_at_stop,
                              input int exp_cnt, input logic [2:0] exp_err);
        wait_tick();
        #1 rx = 1'b0;
        repeat (16) wait_tick();
        for (int i = 0; i < 8; i++) begin
            #1 rx = d[i];
            repeat (16) wait_tick();
        end
`ifdef UART_RX_PARITY_EN
        #1 rx = par;
        repeat (16) wait_tick();
`else
        if (par === 1'bx) $display("note: parity bit unused");
`endif
        #1 rx = stop;
        for (int j = 0; j < 16; j++) begin
            if (j == 8) begin
                if (rd_at_stop) begin
                    repeat (N - 1) @(posedge clk);
                    #1 rd_en = 1'b1;
                    wait_tick();
                    #1 rd_en = 1'b0;
                end else begin
                    wait_tick();
                end
                @(negedge clk);
                check("busy_after_stop", int'(busy), 0);
                check("count_after_stop", int'(cnt), exp_cnt);
                check("err_after_stop", int'({pe, ov, fe}), int'(exp_err));
            end else begin
                wait_tick();
            end
        end
        #1 rx = 1'b1;
        repeat (16) wait_tick();
    endtask

    task automatic read_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 rd_en = 1'b1;
            @(posedge clk);
            #1 rd_en = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] pb;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_empty", int'(empty), 1);
        check("rst_count", int'(cnt), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'({pe, ov, fe}), 0);

        for (int i = 0; i < 10; i++) begin
            b = 8'(8'h20 + i);
            exp_q.push_back(b);
            send_frame(b, 1'b1, ^b, 1'b0, i + 1, 3'b000);
        end
        @(negedge clk);
        check("seq_count", int'(cnt), 10);
        check("seq_head", int'(dout), 'h20);
        read_n(10);
        @(negedge clk);
        check("seq_empty", int'(empty), 1);

        wait_tick();
        #1 rx = 1'b0;
        repeat (4) wait_tick();
        #1 rx = 1'b1;
        repeat (20) wait_tick();
        @(negedge clk);
        check("glitch_busy", int'(busy), 0);
        check("glitch_count", int'(cnt), 0);

        send_frame(8'h55, 1'b0, ^8'h55, 1'b0, 0, 3'b001);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0, 1, 3'b000);
        read_n(1);
        check("framing_pulses", fe_n, 1);

        for (int i = 0; i < 17; i++) begin
            b = 8'(8'h30 + i);
            if (i < 16) exp_q.push_back(b);
            send_frame(b, 1'b1, ^b, 1'b0, (i < 16) ? i + 1 : 16,
                       (i < 16) ? 3'b000 : 3'b010);
        end
        @(negedge clk);
        check("full_head", int'(dout), 'h30);
        check("full_count", int'(cnt), 16);
        check("overrun_pulses", ov_n, 1);

        exp_q.push_back(8'h50);
        send_frame(8'h50, 1'b1, ^8'h50, 1'b1, 16, 3'b000);
        @(negedge clk);
        check("rdwr_overrun", ov_n, 1);
        check("rdwr_head", int'(dout), 'h31);
        read_n(16);
        @(negedge clk);
        check("rdwr_empty", int'(empty), 1);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1, 1'b0, 0, 3'b100);
        exp_q.push_back(8'h03);
        send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1, 3'b000);
        read_n(1);
        check("parity_pulses", pe_n, 1);
`endif

        send_frame(8'h11, 1'b1, ^8'h11, 1'b0, 1, 3'b000);
        pb = 8'hC3;
        wait_tick();
        #1 rx = 1'b0;
        repeat (16) wait_tick();
        for (int i = 0; i < 3; i++) begin
            #1 rx = pb[i];
            repeat (16) wait_tick();
        end
        repeat (5) wait_tick();
        @(negedge clk);
        check("mid_data_busy", int'(busy), 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        check("mrst_empty", int'(empty), 1);
        check("mrst_count", int'(cnt), 0);
        check("mrst_busy", int'(busy), 0);
        repeat (16) wait_tick();
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, ^8'h7E, 1'b0, 1, 3'b000);
        read_n(1);
        @(negedge clk);

        check("sb_drained", exp_q.size(), 0);
        check("total_framing", fe_n, 1);
        check("total_overrun", ov_n, 1);
`ifdef UART_RX_PARITY_EN
        check("total_parity", pe_n, 1);
`else
        check("total_parity", pe_n, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the satellite UART link, the counterpart stage to `uart_tx`. It consumes the asynchronous `rx_p` line, samples it with the 16x strobe from `baud_generator`, and deframes 8N1 characters (optionally 8E1). Received bytes are buffered in an internal 16-entry first-word-fall-through FIFO, which the downstream command logic reads. Framing, overrun and (optionally) parity errors are reported as single-cycle pulses.

## Interface
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 = 16 entries.
- `clk210_p`  in  1  system clock, 210 MHz; all logic on the rising edge.
- `reset_p`  in  1  synchronous, active-high reset.
- `baud_16_x_p`  in  1  one-cycle strobe at 16x the baud rate, from `baud_generator`.
- `rx_p`  in  1  asynchronous serial input; idle high.
- `fifo_rx_dout_p`  out  8  head byte of the FIFO, valid while `fifo_rx_empty_p`=0.
- `fifo_rx_rd_en_p`  in  1  pops the head entry; ignored while empty.
- `fifo_rx_data_count_p`  out  DEPTH_LOG2+1  occupancy, 0..16.
- `fifo_rx_empty_p`  out  1  FIFO empty.
- `rx_busy_p`  out  1  high in any state other than IDLE.
- `framing_error_p`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_p`  out  1  one-cycle pulse: good byte dropped because the FIFO was full.
- `parity_error_p`  out  1  one-cycle pulse on parity mismatch; constant 0 without the macro.

## Operation
- `rx_p` passes through a 2-flop synchronizer (reset value 1) to give `rx_s`. All decisions use `rx_s`.
- A tick is a clock edge with `baud_16_x_p`=1. The 4-bit `tick_cnt` and 3-bit `bit_cnt` advance only on ticks.
- IDLE: on a tick with `rx_s`=0, go to START with `tick_cnt`=0.
- START: when `tick_cnt`=7 (mid start bit):
  - if `rx_s`=0, go to DATA with `tick_cnt`=0 and `bit_cnt`=0;
  - if `rx_s`=1, treat it as a glitch and return to IDLE. No error is raised.
- DATA: at `tick_cnt`=15, shift `rx_s` into the shift register LSB-first.
  - After bit 7, go to STOP, or to PARITY with the macro.
- PARITY (macro only): at `tick_cnt`=15, compare `rx_s` with the even parity of the data byte. Go to STOP.
- STOP: at `tick_cnt`=15 (mid stop bit), return to IDLE on the same edge. A new start edge is accepted from the next tick.
  - `rx_s`=1 and no parity error: the byte is written to the FIFO.
  - `rx_s`=1 and parity error: `parity_error_p` pulses and the byte is discarded.
  - `rx_s`=0: `framing_error_p` pulses and the byte is discarded.
- FIFO write rules:
  - Write while full with no simultaneous read: the byte is dropped and `overrun_p` pulses.
  - Write while full with a simultaneous read: both are performed; the count stays at 16.
  - Write while empty with a simultaneous read: the read is ignored; the count becomes 1.
- Read/write pointers are DEPTH_LOG2 bits and wrap modulo 16. Count = wr − rd and is kept as a separate DEPTH_LOG2+1 counter.
- Reset values:
  - state IDLE; all counters and pointers 0;
  - `fifo_rx_empty_p`=1, `fifo_rx_data_count_p`=0, `fifo_rx_dout_p`=0x00;
  - `rx_busy_p`=0 and all error pulses 0.
- Reset asserted mid-frame abandons the frame and flushes the FIFO. The partial byte is never written.

## Timing
- Synchronizer latency is 2 cycles. A start edge is qualified 8 ticks, plus up to 1 tick of phase uncertainty, after it reaches `rx_s`.
- Stop-bit sample edge = E. From E+1:
  - the byte is visible on `fifo_rx_dout_p`;
  - `fifo_rx_empty_p` falls;
  - the count has incremented;
  - `rx_busy_p` is low.
- Error pulses are registered and are high for exactly the cycle after E.
- Read: with `fifo_rx_rd_en_p` high on edge R, the next entry (or empty=1) is presented from R+1.
- Bit sampling sits at 16-tick intervals from the start-bit centre. This tolerates ±3% baud mismatch.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists, a frame is 11 bits (8E1), and `parity_error_p` is live.
- Undefined: 8N1 framing, no PARITY state, and `parity_error_p` is tied to 0.

## Structure
- Shared package `uart_pkg`:
  - state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - `OVERSAMPLE_c`=16, `MID_TICK_c`=7, `LAST_TICK_c`=15, `DATA_BITS_c`=8.
- One sub-module, `uart_rx_fifo`: a 16x8 FWFT FIFO holding the pointers, count and full/overrun logic. It is shareable with the TX side.

## Test plan
- Reset, then send 0x20..0x29 LSB-first at 16 ticks/bit with idle gaps.
  - Required: count reaches 10; reads return 0x20..0x29 in order; no error pulses.
- 4-tick low glitch on `rx_p` while idle.
  - Required: return to IDLE; FIFO unchanged; no error pulses.
- Byte 0x55 with the stop bit held low.
  - Required: `framing_error_p` pulses once; count unchanged; the next good byte 0xA5 is received.
- Send 17 bytes with no reads.
  - Required: count saturates at 16; `overrun_p` pulses on byte 17; head is still byte 1.
- FIFO full, and a read is issued on edge E of byte 17.
  - Required: count stays 16; no overrun; byte 17 is the tail.
- With `UART_RX_PARITY_EN`, send 0x03 with parity bit 1.
  - Required: `parity_error_p` pulses and the byte is discarded.
  - Then send 0x03 with parity bit 0: the byte is stored.
- Reset asserted mid-DATA.
  - Required: empty=1 and count=0 from the next cycle; a subsequent clean 0x7E is received correctly.
